// File: rtl/dsp_frame_sequencer_if.sv
// dsp_frame_sequencer_if: control inputs and frame/bank status outputs of the frame sequencer
interface dsp_frame_sequencer_if #(parameter int PC_WIDTH = 11);
   logic                enable;
   logic                frame_tgl;
   logic                swap_req;
   logic                clear_err;
   logic [PC_WIDTH-1:0] pc;
   logic                pc_valid;
   logic                frame_start;
   logic                locked;
   logic                slip_err;
   logic [7:0]          slip_count;
   logic                bank_sel;
   logic                swap_ack;
   modport master (
      output enable, frame_tgl, swap_req, clear_err,
      input  pc, pc_valid, frame_start, locked, slip_err, slip_count, bank_sel, swap_ack
   );
   modport slave (
      input  enable, frame_tgl, swap_req, clear_err,
      output pc, pc_valid, frame_start, locked, slip_err, slip_count, bank_sel, swap_ack
   );
endinterface

// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: modulo-N pc aligned to the ADAT frame toggle, with lock/slip tracking and frame-boundary bank swaps
module dsp_frame_sequencer #(
   parameter int CYCLES_PER_FRAME = 2048,
   parameter int PC_WIDTH         = $clog2(CYCLES_PER_FRAME),
   parameter int SYNC_STAGES      = 2,
   parameter int SLIP_TOL         = 2,
   parameter int LOCK_COUNT       = 4
) (
   input logic                  dsp_clk,
   input logic                  reset_n,
   dsp_frame_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(CYCLES_PER_FRAME - 1);
   localparam logic [PC_WIDTH-1:0] WIN_LO  = PC_WIDTH'(CYCLES_PER_FRAME - 1 - SLIP_TOL);
   localparam logic [PC_WIDTH-1:0] WIN_HI  = PC_WIDTH'(SLIP_TOL);
   localparam logic [CW-1:0]       LOCK_N  = CW'(LOCK_COUNT);
   state_t               state, state_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 sync_d, evt;
   logic [PC_WIDTH-1:0]  pc_q, pc_n;
   logic                 valid_q, valid_n, fs_q, fs_n, locked_q, locked_n;
   logic                 err_q, err_n, bank_q, bank_n, ack_q, ack_n, pend_q, pend_n;
   logic                 seen_q, seen_n;
   logic [7:0]           scnt_q, scnt_n, scnt_base;
   logic [CW-1:0]        cnt_q, cnt_n;
   logic                 run, wrap, aligned, slip, good, win_end, miss, do_swap;
   always_ff @(posedge dsp_clk or negedge reset_n)
      if (!reset_n) begin
         sync_q <= '0;
         sync_d <= 1'b0;
         evt    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.frame_tgl};
         sync_d <= sync_q[SYNC_STAGES-1];
         evt    <= sync_q[SYNC_STAGES-1] ^ sync_d;
      end
   // Aligned window spans SLIP_TOL cycles either side of the last pc of the frame.
   assign run     = state == RUN;
   assign wrap    = run && pc_q == PC_LAST;
   assign aligned = pc_q >= WIN_LO || pc_q < WIN_HI;
   assign slip    = run && evt && !aligned;
   assign good    = run && evt && aligned;
   assign win_end = run && pc_q == WIN_HI;
   assign miss    = win_end && !seen_q && !evt;
   always_ff @(posedge dsp_clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state == IDLE      ? (bus.enable ? WAIT_SYNC : IDLE)
              : state == WAIT_SYNC ? (evt ? RUN : bus.enable ? WAIT_SYNC : IDLE)
              : (wrap && !bus.enable) ? IDLE : RUN;
   end
   always_comb begin
      pc_n      = (run && !slip && !wrap) ? pc_q + 1'b1 : '0;
      valid_n   = state_n == RUN;
      fs_n      = valid_n && pc_n == '0;
      do_swap   = fs_n && (pend_q || bus.swap_req);
      bank_n    = bank_q ^ do_swap;
      ack_n     = do_swap;
      pend_n    = !do_swap && (pend_q || bus.swap_req);
      cnt_n     = (slip || miss || !valid_n) ? '0 : (good && cnt_q != LOCK_N) ? cnt_q + 1'b1 : cnt_q;
      locked_n  = valid_n && !slip && !miss && cnt_q == LOCK_N;
      seen_n    = valid_n && (!run || evt || (seen_q && !win_end));
      err_n     = slip || (!bus.clear_err && err_q);
      scnt_base = bus.clear_err ? 8'd0 : scnt_q;
      scnt_n    = (slip && scnt_base != 8'hff) ? scnt_base + 8'd1 : scnt_base;
   end
   always_ff @(posedge dsp_clk or negedge reset_n)
      if (!reset_n) begin
         pc_q     <= '0;
         valid_q  <= 1'b0;
         fs_q     <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         scnt_q   <= '0;
         bank_q   <= 1'b0;
         ack_q    <= 1'b0;
         pend_q   <= 1'b0;
         cnt_q    <= '0;
         seen_q   <= 1'b0;
      end else begin
         pc_q     <= pc_n;
         valid_q  <= valid_n;
         fs_q     <= fs_n;
         locked_q <= locked_n;
         err_q    <= err_n;
         scnt_q   <= scnt_n;
         bank_q   <= bank_n;
         ack_q    <= ack_n;
         pend_q   <= pend_n;
         cnt_q    <= cnt_n;
         seen_q   <= seen_n;
      end
   assign bus.pc          = pc_q;
   assign bus.pc_valid    = valid_q;
   assign bus.frame_start = fs_q;
   assign bus.locked      = locked_q;
   assign bus.slip_err    = err_q;
   assign bus.slip_count  = scnt_q;
   assign bus.bank_sel    = bank_q;
   assign bus.swap_ack    = ack_q;
endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// tb_dsp_frame_sequencer: directed cycle-exact checks of sync, lock, slip, miss, swap, enable and reset behaviour
module tb_dsp_frame_sequencer;
   logic dsp_clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0, errors = 0, cyc = 0, nxt = 0, per = 0;
   int t, t2, g, h, u, v;
   dsp_frame_sequencer_if #(.PC_WIDTH(4)) bus ();
   dsp_frame_sequencer #(
      .CYCLES_PER_FRAME(16), .SYNC_STAGES(2), .SLIP_TOL(2), .LOCK_COUNT(4)
   ) dut (.dsp_clk(dsp_clk), .reset_n(reset_n), .bus(bus.slave));
   always #5 dsp_clk = ~dsp_clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask
   // One clock; frame_tgl toggles on a schedule when per is non-zero.
   task automatic tick();
      @(posedge dsp_clk);
      #1;
      cyc++;
      if (per != 0 && cyc == nxt) begin
         bus.frame_tgl = ~bus.frame_tgl;
         nxt = cyc + per;
      end
   endtask
   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask
   initial begin
      bus.enable = 0; bus.frame_tgl = 0; bus.swap_req = 0; bus.clear_err = 0;
      repeat (3) tick();
      chk("rst_pc", bus.pc, 0);
      chk("rst_valid", bus.pc_valid, 0);
      chk("rst_fs", bus.frame_start, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_slip_err", bus.slip_err, 0);
      chk("rst_slip_cnt", bus.slip_count, 0);
      chk("rst_bank", bus.bank_sel, 0);
      chk("rst_ack", bus.swap_ack, 0);
      reset_n = 1; bus.enable = 1;
      t = cyc + 3; nxt = t; per = 16;
      run_to(t + 3);  chk("t1_wait_valid", bus.pc_valid, 0);
      run_to(t + 4);  chk("t1_first_fs", bus.frame_start, 1); chk("t1_first_pc", bus.pc, 0); chk("t1_first_valid", bus.pc_valid, 1);
      run_to(t + 9);  chk("t1_pc5", bus.pc, 5); chk("t1_fs_low", bus.frame_start, 0);
      run_to(t + 19); chk("t1_pc15", bus.pc, 15);
      run_to(t + 20); chk("t1_wrap_pc", bus.pc, 0); chk("t1_wrap_fs", bus.frame_start, 1);
      run_to(t + 68); chk("t1_not_locked", bus.locked, 0);
      run_to(t + 69); chk("t1_locked", bus.locked, 1);
      run_to(t + 95); nxt = t + 98;
      run_to(t + 98); nxt = t + 112;
      run_to(t + 103); chk("t2_tol_pc", bus.pc, 3); chk("t2_tol_locked", bus.locked, 1); chk("t2_tol_err", bus.slip_err, 0);
      run_to(t + 127); nxt = t + 133;
      run_to(t + 136); chk("t2_preslip_pc", bus.pc, 4);
      run_to(t + 137); chk("t2_slip_pc", bus.pc, 0); chk("t2_slip_fs", bus.frame_start, 1);
      chk("t2_slip_locked", bus.locked, 0); chk("t2_slip_err", bus.slip_err, 1); chk("t2_slip_cnt", bus.slip_count, 1);
      t2 = t + 133;
      run_to(t2 + 70); chk("t3_relocked", bus.locked, 1);
      run_to(t2 + 81); per = 0;
      run_to(t2 + 102); chk("t3_still_locked", bus.locked, 1);
      run_to(t2 + 103); chk("t3_miss_locked", bus.locked, 0); chk("t3_miss_pc", bus.pc, 3); chk("t3_miss_valid", bus.pc_valid, 1);
      run_to(t2 + 116); chk("t3_free_pc", bus.pc, 0); chk("t3_free_fs", bus.frame_start, 1);
      chk("t3_no_slip", bus.slip_count, 1);
      g = t2 + 116;
      run_to(g + 7); chk("t4_pc7", bus.pc, 7);
      bus.swap_req = 1; tick(); bus.swap_req = 0;
      run_to(g + 15); chk("t4_bank_pre", bus.bank_sel, 0); chk("t4_ack_pre", bus.swap_ack, 0);
      run_to(g + 16); chk("t4_bank1", bus.bank_sel, 1); chk("t4_ack1", bus.swap_ack, 1); chk("t4_pc0", bus.pc, 0);
      run_to(g + 17); chk("t4_ack_pulse", bus.swap_ack, 0);
      run_to(g + 19); bus.swap_req = 1; tick(); bus.swap_req = 0;
      run_to(g + 25); bus.swap_req = 1; tick(); bus.swap_req = 0;
      run_to(g + 32); chk("t4_dbl_bank", bus.bank_sel, 0); chk("t4_dbl_ack", bus.swap_ack, 1);
      run_to(g + 33); chk("t4_dbl_ack_low", bus.swap_ack, 0);
      run_to(g + 47); chk("t4_single_toggle", bus.bank_sel, 0);
      bus.swap_req = 1; tick(); bus.swap_req = 0;
      chk("t4_at0_bank", bus.bank_sel, 1); chk("t4_at0_ack", bus.swap_ack, 1); chk("t4_at0_pc", bus.pc, 0);
      run_to(g + 49); chk("t4_at0_ack_low", bus.swap_ack, 0);
      h = g + 64;
      run_to(h + 5); chk("t5_pc5", bus.pc, 5); bus.enable = 0;
      run_to(h + 15); chk("t5_finish_pc", bus.pc, 15); chk("t5_finish_valid", bus.pc_valid, 1);
      run_to(h + 16); chk("t5_idle_pc", bus.pc, 0); chk("t5_idle_valid", bus.pc_valid, 0);
      chk("t5_idle_fs", bus.frame_start, 0); chk("t5_idle_locked", bus.locked, 0);
      run_to(h + 20); chk("t5_idle_hold", bus.pc_valid, 0);
      bus.enable = 1;
      u = h + 22;
      run_to(u); bus.frame_tgl = ~bus.frame_tgl;
      run_to(u + 4); chk("t5_resync_fs", bus.frame_start, 1);
      run_to(u + 6); bus.frame_tgl = ~bus.frame_tgl;
      run_to(u + 9); chk("t5_preslip_pc", bus.pc, 5);
      bus.clear_err = 1; tick(); bus.clear_err = 0;
      chk("t5_slipclr_pc", bus.pc, 0); chk("t5_slipclr_err", bus.slip_err, 1); chk("t5_slipclr_cnt", bus.slip_count, 1);
      chk("t5_bank_kept", bus.bank_sel, 1);
      tick(); bus.clear_err = 1; tick(); bus.clear_err = 0;
      chk("t5_clr_err", bus.slip_err, 0); chk("t5_clr_cnt", bus.slip_count, 0);
      run_to(u + 19); chk("t6_pc9", bus.pc, 9);
      reset_n = 0; bus.enable = 0;
      #1;
      chk("t6_async_pc", bus.pc, 0); chk("t6_async_valid", bus.pc_valid, 0);
      chk("t6_async_bank", bus.bank_sel, 0); chk("t6_async_fs", bus.frame_start, 0);
      tick(); tick(); reset_n = 1;
      repeat (3) tick();
      bus.enable = 1; tick();
      v = cyc + 1;
      run_to(v); bus.frame_tgl = ~bus.frame_tgl;
      run_to(v + 3); chk("t6_wait_valid", bus.pc_valid, 0);
      run_to(v + 4); chk("t6_fs", bus.frame_start, 1); chk("t6_pc0", bus.pc, 0);
      run_to(v + 5); chk("t6_pc1", bus.pc, 1); chk("t6_bank", bus.bank_sel, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
